// File: rtl/l2_request_arbiter_if.sv
// Bundle of L1 instruction-cache, L1 data-cache and L2 request/response
// signals that pass through the L2 request arbiter.
// slave  : the arbiter's view (takes L1 requests, drives the L2 request).
// master : the surrounding caches' view (drives L1 requests, drives L2 response).
interface l2_request_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_mem_read;
    logic              i_mem_write;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_wdata;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;

    logic              l2_mem_read;
    logic              l2_mem_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic              l2_resp;
    logic [LINE_W-1:0] l2_rdata;

    logic              grant_d;
    logic              busy;

    modport slave (
        input  i_mem_read, i_mem_write, i_address, i_wdata,
        output i_resp, i_rdata,
        input  d_mem_read, d_mem_write, d_address, d_wdata,
        output d_resp, d_rdata,
        output l2_mem_read, l2_mem_write, l2_address, l2_wdata,
        input  l2_resp, l2_rdata,
        output grant_d, busy
    );

    modport master (
        output i_mem_read, i_mem_write, i_address, i_wdata,
        input  i_resp, i_rdata,
        output d_mem_read, d_mem_write, d_address, d_wdata,
        input  d_resp, d_rdata,
        input  l2_mem_read, l2_mem_write, l2_address, l2_wdata,
        output l2_resp, l2_rdata,
        input  grant_d, busy
    );
endinterface

// File: rtl/l2_request_arbiter.sv
// L2 request arbiter: shares one unified L2 cache between the L1 I-cache and
// the L1 D-cache. One grant at a time; while held, the winner's request is
// forwarded to L2 and the L2 response strobe is returned only to the winner.
// Every grant is followed by at least one IDLE cycle.
// Build option: define L2_ARB_ROUND_ROBIN_EN to break I/D ties by alternating
// against the last completed grant; otherwise D always wins ties.
module l2_request_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input logic                  clk,
    input logic                  reset,
    l2_request_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            state;
    logic              busy_q;
    logic              grant_d_q;
    logic              last_d;       // 1 = last completed grant went to D
    logic              i_req;
    logic              d_req;
    logic              d_wins_tie;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_data;
    logic              i_resp;
    logic              d_resp;

    // A port is requesting when it asserts read, write, or both.
    assign i_req = bus.i_mem_read | bus.i_mem_write;
    assign d_req = bus.d_mem_read | bus.d_mem_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
    // Tie goes to whichever port did not complete the previous grant.
    assign d_wins_tie = ~last_d;
`else
    // Fixed priority: D wins every tie whatever the grant history says.
    assign d_wins_tie = last_d | ~last_d;
`endif

    // Grant FSM with registered busy/grant_d and last-grant history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            grant_d_q <= 1'b0;
            last_d    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && (!i_req || d_wins_tie)) begin
                        state     <= GRANT_D;
                        busy_q    <= 1'b1;
                        grant_d_q <= 1'b1;
                    end else if (i_req) begin
                        state     <= GRANT_I;
                        busy_q    <= 1'b1;
                        grant_d_q <= 1'b0;
                    end
                end
                GRANT_I: begin
                    if (bus.l2_resp) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        last_d <= 1'b0;
                    end else if (!i_req) begin
                        // Abort: requester withdrew before L2 answered.
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (bus.l2_resp) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        grant_d_q <= 1'b0;
                        last_d    <= 1'b1;
                    end else if (!d_req) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        grant_d_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    grant_d_q <= 1'b0;
                end
            endcase
        end
    end

    // Forward the owner's request to L2 and steer the response strobe back.
    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_addr  = '0;
        l2_data  = '0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        case (state)
            GRANT_I: begin
                l2_read  = bus.i_mem_read;
                l2_write = bus.i_mem_write;
                l2_addr  = bus.i_address;
                l2_data  = bus.i_wdata;
                i_resp   = bus.l2_resp;
            end
            GRANT_D: begin
                l2_read  = bus.d_mem_read;
                l2_write = bus.d_mem_write;
                l2_addr  = bus.d_address;
                l2_data  = bus.d_wdata;
                d_resp   = bus.l2_resp;
            end
            default: ;
        endcase
    end

    assign bus.l2_mem_read  = l2_read;
    assign bus.l2_mem_write = l2_write;
    assign bus.l2_address   = l2_addr;
    assign bus.l2_wdata     = l2_data;
    assign bus.i_resp       = i_resp;
    assign bus.d_resp       = d_resp;
    // Read data is broadcast; only the response strobe identifies the owner.
    assign bus.i_rdata      = bus.l2_rdata;
    assign bus.d_rdata      = bus.l2_rdata;
    assign bus.busy         = busy_q;
    assign bus.grant_d      = grant_d_q;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// Testbench for l2_request_arbiter: directed scenarios followed by a
// randomized run checked against a port-ownership reference model.
module tb_l2_request_arbiter;
    logic clk;
    logic reset;
    integer total;
    integer bad;

    l2_request_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

    l2_request_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive_idle();
        bus.i_mem_read  = 1'b0;
        bus.i_mem_write = 1'b0;
        bus.i_address   = '0;
        bus.i_wdata     = '0;
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
        bus.d_address   = '0;
        bus.d_wdata     = '0;
        bus.l2_resp     = 1'b0;
        bus.l2_rdata    = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.grant_d !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold busy=%b grant_d=%b expected 0 0", bus.busy, bus.grant_d);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            total++;
            if ({bus.busy, bus.grant_d, bus.i_resp, bus.d_resp, bus.l2_mem_read, bus.l2_mem_write} !== 6'b0
                || bus.l2_address !== 32'h0 || bus.l2_wdata !== 256'h0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d busy=%b grant_d=%b l2_rd=%b l2_wr=%b addr=%h expected all 0",
                         c, bus.busy, bus.grant_d, bus.l2_mem_read, bus.l2_mem_write, bus.l2_address);
            end
        end
        @(negedge clk);
        bus.l2_resp = 1'b1;
        #1;
        total++;
        if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
            bad++;
            $display("FAIL idle_resp i_resp=%b d_resp=%b expected 0 0", bus.i_resp, bus.d_resp);
        end
        @(negedge clk);
        bus.l2_resp = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_resp_state busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_single_i();
        logic [255:0] pat;
        pat = {32{8'hA5}};
        @(negedge clk);
        bus.i_mem_read = 1'b1;
        bus.i_address  = 32'h0000_1000;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.l2_mem_read !== 1'b0) begin
            bad++;
            $display("FAIL single_i_latency busy=%b l2_rd=%b expected 0 0", bus.busy, bus.l2_mem_read);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.grant_d !== 1'b0 || bus.l2_mem_read !== 1'b1
            || bus.l2_mem_write !== 1'b0 || bus.l2_address !== 32'h0000_1000) begin
            bad++;
            $display("FAIL single_i_grant busy=%b grant_d=%b l2_rd=%b l2_wr=%b addr=%h expected 1 0 1 0 00001000",
                     bus.busy, bus.grant_d, bus.l2_mem_read, bus.l2_mem_write, bus.l2_address);
        end
        repeat (3) @(negedge clk);
        @(negedge clk);
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = pat;
        #1;
        total++;
        if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0 || bus.i_rdata !== pat) begin
            bad++;
            $display("FAIL single_i_resp i_resp=%b d_resp=%b i_rdata=%h expected 1 0 %h",
                     bus.i_resp, bus.d_resp, bus.i_rdata, pat);
        end
        @(negedge clk);
        bus.l2_resp    = 1'b0;
        bus.i_mem_read = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.i_resp !== 1'b0) begin
            bad++;
            $display("FAIL single_i_done busy=%b i_resp=%b expected 0 0", bus.busy, bus.i_resp);
        end
    endtask

    task automatic test_tie();
        logic [255:0] wpat;
        wpat = {32{8'h3C}};
        @(negedge clk);
        bus.i_mem_read  = 1'b1;
        bus.i_address   = 32'h100;
        bus.d_mem_write = 1'b1;
        bus.d_address   = 32'h200;
        bus.d_wdata     = wpat;
        @(negedge clk);
        #1;
        total++;
        if (bus.grant_d !== 1'b1 || bus.busy !== 1'b1 || bus.l2_mem_write !== 1'b1
            || bus.l2_mem_read !== 1'b0 || bus.l2_address !== 32'h200 || bus.l2_wdata !== wpat) begin
            bad++;
            $display("FAIL tie_d_first grant_d=%b busy=%b l2_wr=%b l2_rd=%b addr=%h expected 1 1 1 0 00000200",
                     bus.grant_d, bus.busy, bus.l2_mem_write, bus.l2_mem_read, bus.l2_address);
        end
        @(negedge clk);
        bus.l2_resp = 1'b1;
        #1;
        total++;
        if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin
            bad++;
            $display("FAIL tie_d_resp d_resp=%b i_resp=%b expected 1 0", bus.d_resp, bus.i_resp);
        end
        @(negedge clk);
        bus.l2_resp     = 1'b0;
        bus.d_mem_write = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL tie_idle_gap busy=%b expected 0", bus.busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.grant_d !== 1'b0 || bus.l2_mem_read !== 1'b1 || bus.l2_address !== 32'h100) begin
            bad++;
            $display("FAIL tie_i_second busy=%b grant_d=%b l2_rd=%b addr=%h expected 1 0 1 00000100",
                     bus.busy, bus.grant_d, bus.l2_mem_read, bus.l2_address);
        end
        @(negedge clk);
        bus.l2_resp = 1'b1;
        #1;
        total++;
        if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin
            bad++;
            $display("FAIL tie_i_resp i_resp=%b d_resp=%b expected 1 0", bus.i_resp, bus.d_resp);
        end
        @(negedge clk);
        bus.l2_resp    = 1'b0;
        bus.i_mem_read = 1'b0;
    endtask

    task automatic test_fair();
        logic exp_d;
        logic last_d;
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        bus.i_mem_read = 1'b1;
        bus.i_address  = 32'h4000;
        bus.d_mem_read = 1'b1;
        bus.d_address  = 32'h8000;
        last_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef L2_ARB_ROUND_ROBIN_EN
            exp_d = ~last_d;
`else
            exp_d = 1'b1;
`endif
            last_d = exp_d;
            #1;
            total++;
            if (bus.busy !== 1'b1 || bus.grant_d !== exp_d) begin
                bad++;
                $display("FAIL fair_grant %0d busy=%b grant_d=%b expected 1 %b", k, bus.busy, bus.grant_d, exp_d);
            end
            bus.l2_resp = 1'b1;
            #1;
            total++;
            if (bus.d_resp !== exp_d || bus.i_resp !== ~exp_d) begin
                bad++;
                $display("FAIL fair_resp %0d d_resp=%b i_resp=%b expected %b %b", k, bus.d_resp, bus.i_resp, exp_d, ~exp_d);
            end
            @(negedge clk);
            bus.l2_resp = 1'b0;
            if (k == 3) begin
                bus.i_mem_read = 1'b0;
                bus.d_mem_read = 1'b0;
            end
            #1;
            total++;
            if (bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL fair_gap %0d busy=%b expected 0", k, bus.busy);
            end
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        bus.i_mem_read = 1'b1;
        bus.i_address  = 32'h0000_0A00;
        @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.grant_d !== 1'b0) begin
            bad++;
            $display("FAIL abort_grant busy=%b grant_d=%b expected 1 0", bus.busy, bus.grant_d);
        end
        @(negedge clk);
        bus.d_mem_read = 1'b1;
        bus.d_address  = 32'h0000_0B00;
        @(negedge clk);
        bus.i_mem_read = 1'b0;
        #1;
        total++;
        if (bus.i_resp !== 1'b0 || bus.l2_mem_read !== 1'b0) begin
            bad++;
            $display("FAIL abort_drop i_resp=%b l2_rd=%b expected 0 0", bus.i_resp, bus.l2_mem_read);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.i_resp !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle busy=%b i_resp=%b expected 0 0", bus.busy, bus.i_resp);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.grant_d !== 1'b1 || bus.l2_address !== 32'h0000_0B00) begin
            bad++;
            $display("FAIL abort_d_grant busy=%b grant_d=%b addr=%h expected 1 1 00000b00",
                     bus.busy, bus.grant_d, bus.l2_address);
        end
        @(negedge clk);
        bus.l2_resp = 1'b1;
        @(negedge clk);
        bus.l2_resp    = 1'b0;
        bus.d_mem_read = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.d_mem_read = 1'b1;
        bus.d_address  = 32'h0000_C000;
        @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.grant_d !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre busy=%b grant_d=%b expected 1 1", bus.busy, bus.grant_d);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.grant_d !== 1'b0 || bus.l2_mem_read !== 1'b0 || bus.l2_address !== 32'h0) begin
            bad++;
            $display("FAIL areset_now busy=%b grant_d=%b l2_rd=%b addr=%h expected 0 0 0 00000000",
                     bus.busy, bus.grant_d, bus.l2_mem_read, bus.l2_address);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL areset_release busy=%b expected 0", bus.busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.grant_d !== 1'b1 || bus.l2_address !== 32'h0000_C000) begin
            bad++;
            $display("FAIL areset_regrant busy=%b grant_d=%b addr=%h expected 1 1 0000c000",
                     bus.busy, bus.grant_d, bus.l2_address);
        end
        @(negedge clk);
        bus.l2_resp = 1'b1;
        @(negedge clk);
        bus.l2_resp    = 1'b0;
        bus.d_mem_read = 1'b0;
    endtask

    task automatic test_random();
        // Reference model: owner is -1 (nobody), 0 (I port) or 1 (D port).
        int           owner;
        int           last_owner;
        logic         req [2];
        logic         done [2];
        logic         resp;
        int           mode;
        logic         e_rd;
        logic         e_wr;
        logic [31:0]  e_addr;
        logic [255:0] e_wd;
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        owner      = -1;
        last_owner = 0;
        done[0]    = 1'b0;
        done[1]    = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            // I-cache agent
            if (done[0]) begin
                bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0; done[0] = 1'b0;
            end else if (!(bus.i_mem_read || bus.i_mem_write)) begin
                if ($urandom_range(0, 2) == 0) begin
                    mode = int'($urandom_range(0, 3));
                    bus.i_mem_read  = (mode != 2);
                    bus.i_mem_write = (mode >= 2);
                    bus.i_address   = $urandom;
                    bus.i_wdata     = rand_line();
                end
            end else if ($urandom_range(0, 31) == 0) begin
                bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0;
            end
            // D-cache agent
            if (done[1]) begin
                bus.d_mem_read = 1'b0; bus.d_mem_write = 1'b0; done[1] = 1'b0;
            end else if (!(bus.d_mem_read || bus.d_mem_write)) begin
                if ($urandom_range(0, 2) == 0) begin
                    mode = int'($urandom_range(0, 3));
                    bus.d_mem_read  = (mode != 2);
                    bus.d_mem_write = (mode >= 2);
                    bus.d_address   = $urandom;
                    bus.d_wdata     = rand_line();
                end
            end else if ($urandom_range(0, 31) == 0) begin
                bus.d_mem_read = 1'b0; bus.d_mem_write = 1'b0;
            end
            // L2 responder, including occasional stray responses while idle
            resp = (owner >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            bus.l2_resp  = resp;
            bus.l2_rdata = rand_line();
            req[0] = bus.i_mem_read || bus.i_mem_write;
            req[1] = bus.d_mem_read || bus.d_mem_write;
            // expected L2-side request is exactly the owner's request
            e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
            if (owner == 0) begin
                e_rd = bus.i_mem_read; e_wr = bus.i_mem_write; e_addr = bus.i_address; e_wd = bus.i_wdata;
            end else if (owner == 1) begin
                e_rd = bus.d_mem_read; e_wr = bus.d_mem_write; e_addr = bus.d_address; e_wd = bus.d_wdata;
            end
            #1;
            total++;
            if (bus.busy !== (owner >= 0) || bus.grant_d !== (owner == 1)) begin
                bad++;
                $display("FAIL rand_owner cyc %0d busy=%b grant_d=%b expected %b %b",
                         c, bus.busy, bus.grant_d, owner >= 0, owner == 1);
            end
            total++;
            if (bus.i_resp !== (owner == 0 && resp) || bus.d_resp !== (owner == 1 && resp)) begin
                bad++;
                $display("FAIL rand_resp cyc %0d i_resp=%b d_resp=%b expected %b %b",
                         c, bus.i_resp, bus.d_resp, owner == 0 && resp, owner == 1 && resp);
            end
            total++;
            if (bus.l2_mem_read !== e_rd || bus.l2_mem_write !== e_wr || bus.l2_address !== e_addr) begin
                bad++;
                $display("FAIL rand_l2req cyc %0d rd=%b wr=%b addr=%h expected %b %b %h",
                         c, bus.l2_mem_read, bus.l2_mem_write, bus.l2_address, e_rd, e_wr, e_addr);
            end
            total++;
            if (bus.l2_wdata !== e_wd) begin
                bad++;
                $display("FAIL rand_l2wdata cyc %0d got=%h expected %h", c, bus.l2_wdata, e_wd);
            end
            total++;
            if (bus.i_rdata !== bus.l2_rdata || bus.d_rdata !== bus.l2_rdata) begin
                bad++;
                $display("FAIL rand_rdata cyc %0d i=%h d=%h expected %h", c, bus.i_rdata, bus.d_rdata, bus.l2_rdata);
            end
            // advance model across the coming clock edge
            if (owner >= 0) begin
                if (resp) begin
                    done[owner] = 1'b1;
                    last_owner  = owner;
                    owner       = -1;
                end else if (!req[owner]) begin
                    owner = -1;
                end
            end else if (req[0] && req[1]) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
                owner = 1 - last_owner;
`else
                owner = 1;
`endif
            end else if (req[1]) begin
                owner = 1;
            end else if (req[0]) begin
                owner = 0;
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_i();
        test_tie();
        test_fair();
        test_abort();
        test_async_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
